mac_learn_arbiter: RTL and testbench

//  Parametrised successor to the per-port source-address (SA) learn arbiter feeding the MAC table.

---
 rtl/mac_learn_arbiter_pkg.sv | 22 ++
 rtl/mac_rr_picker.sv | 66 ++++++
 rtl/mac_learn_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mac_learn_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_learn_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mac_learn_arbiter_pkg
//   Shared constants for the source-address learn arbiter and its picker.
//   - MODE_RR / MODE_FIXED : arbitration mode encodings for pMODE
//   - DEFAULT_*            : default port count, SA width and drop-counter width
//   - idx_width()          : index width for a given port count (never below 1)
// ---------------------------------------------------------------------------
package mac_learn_arbiter_pkg;

    localparam int MODE_RR          = 0;
    localparam int MODE_FIXED       = 1;

    localparam int DEFAULT_PORT_NUM = 4;
    localparam int DEFAULT_MAC_W    = 48;
    localparam int DEFAULT_DROP_W   = 8;

    // Width of a port index; a single port still needs one bit to be legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : mac_learn_arbiter_pkg

// File: rtl/mac_rr_picker.sv
// ---------------------------------------------------------------------------
// mac_rr_picker
//   Combinational work-conserving picker over a request vector.
//   Ports:
//     i_req     in   pN       request vector (one bit per full holding slot)
//     i_start   in   pIDX_W   round-robin start index (ignored in fixed mode)
//     i_mode    in   1        0 = round-robin from i_start, 1 = lowest index wins
//     o_found   out  1        at least one request present
//     o_winner  out  pIDX_W   index of the chosen request
//   The wrapped search from i_start is done as mask-then-priority-encode:
//   requests at or above the start index are tried first; if none, the
//   lowest request overall wins, which is exactly the wrap-around case.
// ---------------------------------------------------------------------------
module mac_rr_picker
    import mac_learn_arbiter_pkg::*;
#(
    parameter int pN     = DEFAULT_PORT_NUM,
    parameter int pIDX_W = idx_width(pN)
) (
    input  logic [pN-1:0]     i_req,
    input  logic [pIDX_W-1:0] i_start,
    input  logic              i_mode,
    output logic              o_found,
    output logic [pIDX_W-1:0] o_winner
);

    logic [pIDX_W-1:0] start_eff;
    logic [pN-1:0]     upper_req;
    logic              upper_found;
    logic              lower_found;
    logic [pIDX_W-1:0] upper_idx;
    logic [pIDX_W-1:0] lower_idx;

    always_comb begin
        // NOTE: every variable gets a default before any conditional update,
        // otherwise paths that skip an assignment infer a latch.
        start_eff   = i_mode ? '0 : i_start;
        upper_req   = '0;
        upper_found = 1'b0;
        lower_found = 1'b0;
        upper_idx   = '0;
        lower_idx   = '0;

        for (int i = 0; i < pN; i++) begin
            if (pIDX_W'(i) >= start_eff) begin
                upper_req[i] = i_req[i];
            end
        end

        // Scan downward so the last hit written is the lowest index.
        for (int i = pN - 1; i >= 0; i--) begin
            if (upper_req[i]) begin
                upper_found = 1'b1;
                upper_idx   = pIDX_W'(i);
            end
            if (i_req[i]) begin
                lower_found = 1'b1;
                lower_idx   = pIDX_W'(i);
            end
        end

        o_found  = lower_found;
        o_winner = upper_found ? upper_idx : lower_idx;
    end

endmodule : mac_rr_picker

// File: rtl/mac_learn_arbiter.sv
// ---------------------------------------------------------------------------
// mac_learn_arbiter
//   Collects learned source addresses from each port into a one-entry holding
//   slot per port, picks one full slot per cycle (round-robin or fixed
//   priority) and presents {port, SA} to the MAC table writer over valid/ready.
//   Ports:
//     iclk        in   1                   clock
//     irst_n      in   1                   synchronous active-low reset
//     i_sa_valid  in   pPORT_NUM           per-port strobe: SA available
//     i_sa_data   in   pPORT_NUM*pMAC_W    flattened SAs, port k at [k*pMAC_W +: pMAC_W]
//     i_ready     in   1                   table writer accepts current output
//     o_valid     out  1                   output entry valid
//     o_port_num  out  idx_width(pPORT_NUM) source port of output entry
//     o_sa        out  pMAC_W              SA of output entry
//     o_grant     out  pPORT_NUM           one-hot pulse: slot freed by this load
//     o_drop_cnt  out  pPORT_NUM*pDROP_W   flattened saturating drop counters
// ---------------------------------------------------------------------------
module mac_learn_arbiter
    import mac_learn_arbiter_pkg::*;
#(
    parameter int  pPORT_NUM = DEFAULT_PORT_NUM,
    parameter int  pMAC_W    = DEFAULT_MAC_W,
    parameter int  pMODE     = MODE_RR,
    parameter int  pDROP_W   = DEFAULT_DROP_W,
    localparam int pIDX_W    = idx_width(pPORT_NUM)
) (
    input  logic                          iclk,
    input  logic                          irst_n,
    input  logic [pPORT_NUM-1:0]          i_sa_valid,
    input  logic [pPORT_NUM*pMAC_W-1:0]   i_sa_data,
    input  logic                          i_ready,
    output logic                          o_valid,
    output logic [pIDX_W-1:0]             o_port_num,
    output logic [pMAC_W-1:0]             o_sa,
    output logic [pPORT_NUM-1:0]          o_grant,
    output logic [pPORT_NUM*pDROP_W-1:0]  o_drop_cnt
);

    // Holding slots
    logic [pPORT_NUM-1:0] slot_full_q, slot_full_d;
    logic [pMAC_W-1:0]    slot_sa_q [pPORT_NUM];
    logic [pPORT_NUM-1:0] capture;

    // Drop counters
    logic [pDROP_W-1:0]   drop_cnt_q [pPORT_NUM];
    logic [pDROP_W-1:0]   drop_cnt_d [pPORT_NUM];

    // Round-robin pointer
    logic [pIDX_W-1:0]    ptr_q, ptr_d;
    logic [pIDX_W:0]      ptr_inc;

    // Output register
    logic                 valid_q, valid_d;
    logic [pIDX_W-1:0]    port_q, port_d;
    logic [pMAC_W-1:0]    sa_q, sa_d;
    logic [pPORT_NUM-1:0] grant_q, grant_d;

    // Arbitration
    logic                 load;
    logic                 found;
    logic [pIDX_W-1:0]    winner;

    mac_rr_picker #(
        .pN     (pPORT_NUM),
        .pIDX_W (pIDX_W)
    ) u_picker (
        .i_req    (slot_full_q),
        .i_start  (ptr_q),
        .i_mode   (pMODE == MODE_FIXED),
        .o_found  (found),
        .o_winner (winner)
    );

    // The output register accepts a new entry whenever it is empty or being
    // drained this cycle, and there is something to send.
    assign load = (!valid_q || i_ready) && found;

    always_comb begin
        // NOTE: combinational logic uses blocking assignments so later
        // statements see the updated values; registers below use <= only.
        grant_d = '0;
        if (load) begin
            grant_d[winner] = 1'b1;
        end

        for (int k = 0; k < pPORT_NUM; k++) begin
            // A slot freed this cycle can take a new SA at the same edge.
            capture[k]     = i_sa_valid[k] && (!slot_full_q[k] || grant_d[k]);
            slot_full_d[k] = capture[k] || (slot_full_q[k] && !grant_d[k]);

            drop_cnt_d[k] = drop_cnt_q[k];
            if (i_sa_valid[k] && slot_full_q[k] && !grant_d[k]
                && (drop_cnt_q[k] != '1)) begin
                drop_cnt_d[k] = drop_cnt_q[k] + pDROP_W'(1);
            end
        end

        // Increment one bit wider so pPORT_NUM itself is representable,
        // then wrap; this works for non-power-of-two port counts.
        ptr_inc = {1'b0, winner} + (pIDX_W + 1)'(1);
        ptr_d   = ptr_q;
        if (load && (pMODE == MODE_RR)) begin
            ptr_d = (ptr_inc == (pIDX_W + 1)'(pPORT_NUM)) ? '0 : ptr_inc[pIDX_W-1:0];
        end

        valid_d = valid_q;
        port_d  = port_q;
        sa_d    = sa_q;
        if (load) begin
            valid_d = 1'b1;
            port_d  = winner;
            sa_d    = slot_sa_q[winner];
        end else if (i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            slot_full_q <= '0;
            ptr_q       <= '0;
            valid_q     <= 1'b0;
            port_q      <= '0;
            sa_q        <= '0;
            grant_q     <= '0;
            for (int k = 0; k < pPORT_NUM; k++) begin
                drop_cnt_q[k] <= '0;
            end
        end else begin
            slot_full_q <= slot_full_d;
            ptr_q       <= ptr_d;
            valid_q     <= valid_d;
            port_q      <= port_d;
            sa_q        <= sa_d;
            grant_q     <= grant_d;
            for (int k = 0; k < pPORT_NUM; k++) begin
                drop_cnt_q[k] <= drop_cnt_d[k];
            end
        end
    end

    // NOTE: SA storage has no reset; contents only matter while the slot's
    // full flag is set, and that flag is reset.
    always_ff @(posedge iclk) begin
        for (int k = 0; k < pPORT_NUM; k++) begin
            if (capture[k]) begin
                slot_sa_q[k] <= i_sa_data[k*pMAC_W +: pMAC_W];
            end
        end
    end

    always_comb begin
        o_drop_cnt = '0;
        for (int k = 0; k < pPORT_NUM; k++) begin
            o_drop_cnt[k*pDROP_W +: pDROP_W] = drop_cnt_q[k];
        end
    end

    assign o_valid    = valid_q;
    assign o_port_num = port_q;
    assign o_sa       = sa_q;
    assign o_grant    = grant_q;

endmodule : mac_learn_arbiter

// File: tb/tb_mac_learn_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mac_learn_arbiter
//   Directed bench with hand-computed expectations. Four instances:
//     a: 4 ports, round-robin, 8-bit drop counters
//     b: 4 ports, fixed priority
//     c: 4 ports, round-robin, 2-bit drop counters (saturation)
//     d: 3 ports, round-robin (non-power-of-two pointer wrap)
//   Inputs change 1 time unit after the rising edge; outputs are read there.
// ---------------------------------------------------------------------------
module tb_mac_learn_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance a
    logic [3:0]   va;  logic [191:0] da;  logic ra;
    logic         ova; logic [1:0]   pa;  logic [47:0] sa_a; logic [3:0] ga; logic [31:0] dra;
    // Instance b
    logic [3:0]   vb;  logic [191:0] db;  logic rb;
    logic         ovb; logic [1:0]   pb;  logic [47:0] sa_b; logic [3:0] gb; logic [31:0] drb;
    // Instance c
    logic [3:0]   vc;  logic [191:0] dc;  logic rc;
    logic         ovc; logic [1:0]   pc;  logic [47:0] sa_c; logic [3:0] gc; logic [7:0]  drc;
    // Instance d
    logic [2:0]   vd;  logic [143:0] dd;  logic rd;
    logic         ovd; logic [1:0]   pd;  logic [47:0] sa_d; logic [2:0] gd; logic [23:0] drd;

    mac_learn_arbiter #(.pPORT_NUM(4), .pMAC_W(48), .pMODE(0), .pDROP_W(8)) dut_a (
        .iclk(clk), .irst_n(rst_n), .i_sa_valid(va), .i_sa_data(da), .i_ready(ra),
        .o_valid(ova), .o_port_num(pa), .o_sa(sa_a), .o_grant(ga), .o_drop_cnt(dra));

    mac_learn_arbiter #(.pPORT_NUM(4), .pMAC_W(48), .pMODE(1), .pDROP_W(8)) dut_b (
        .iclk(clk), .irst_n(rst_n), .i_sa_valid(vb), .i_sa_data(db), .i_ready(rb),
        .o_valid(ovb), .o_port_num(pb), .o_sa(sa_b), .o_grant(gb), .o_drop_cnt(drb));

    mac_learn_arbiter #(.pPORT_NUM(4), .pMAC_W(48), .pMODE(0), .pDROP_W(2)) dut_c (
        .iclk(clk), .irst_n(rst_n), .i_sa_valid(vc), .i_sa_data(dc), .i_ready(rc),
        .o_valid(ovc), .o_port_num(pc), .o_sa(sa_c), .o_grant(gc), .o_drop_cnt(drc));

    mac_learn_arbiter #(.pPORT_NUM(3), .pMAC_W(48), .pMODE(0), .pDROP_W(8)) dut_d (
        .iclk(clk), .irst_n(rst_n), .i_sa_valid(vd), .i_sa_data(dd), .i_ready(rd),
        .o_valid(ovd), .o_port_num(pd), .o_sa(sa_d), .o_grant(gd), .o_drop_cnt(drd));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] sa_of(input int port, input int tag);
        return 48'hA000_0000_0000 | (48'(tag) << 8) | 48'(port);
    endfunction

    task automatic apply_reset();
        va = '0; vb = '0; vc = '0; vd = '0;
        ra = 1'b1; rb = 1'b1; rc = 1'b1; rd = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        da = '0; db = '0; dc = '0; dd = '0;
        apply_reset();

        // ---- Reset state ----
        check("rst_valid", 64'(ova),  64'h0);
        check("rst_port",  64'(pa),   64'h0);
        check("rst_sa",    64'(sa_a), 64'h0);
        check("rst_grant", 64'(ga),   64'h0);
        check("rst_drop",  64'(dra),  64'h0);

        // ---- Single SA on port 2, two-cycle latency ----
        va = 4'b0100;
        da[2*48 +: 48] = 48'h0A0B0C0D0E0F;
        tick();
        va = '0;
        check("t1_valid_n1", 64'(ova), 64'h0);
        tick();
        check("t1_valid_n2", 64'(ova),  64'h1);
        check("t1_port",     64'(pa),   64'h2);
        check("t1_sa",       64'(sa_a), 64'h0A0B0C0D0E0F);
        check("t1_grant",    64'(ga),   64'h4);
        tick();
        check("t1_valid_end", 64'(ova), 64'h0);
        check("t1_grant_end", 64'(ga),  64'h0);

        // ---- Round-robin: two all-port bursts ----
        apply_reset();
        for (int k = 0; k < 4; k++) da[k*48 +: 48] = sa_of(k, 1);
        va = 4'hF;
        tick();
        va = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("t2a_valid%0d", k), 64'(ova),  64'h1);
            check($sformatf("t2a_port%0d", k),  64'(pa),   64'(k));
            check($sformatf("t2a_sa%0d", k),    64'(sa_a), 64'(sa_of(k, 1)));
            check($sformatf("t2a_grant%0d", k), 64'(ga),   64'(1 << k));
        end
        for (int k = 0; k < 4; k++) da[k*48 +: 48] = sa_of(k, 2);
        va = 4'hF;
        tick();
        va = '0;
        check("t2_gap_valid", 64'(ova), 64'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("t2b_port%0d", k), 64'(pa),   64'(k));
            check($sformatf("t2b_sa%0d", k),   64'(sa_a), 64'(sa_of(k, 2)));
        end
        // Pointer at 0; port 0 re-posts as it is granted, so port 2 must win next.
        da[0 +: 48]    = sa_of(0, 20);
        da[2*48 +: 48] = sa_of(2, 20);
        va = 4'b0101;
        tick();
        da[0 +: 48] = sa_of(0, 21);
        va = 4'b0001;
        tick();
        va = '0;
        check("t2c_port0", 64'(pa),   64'h0);
        check("t2c_sa0",   64'(sa_a), 64'(sa_of(0, 20)));
        tick();
        check("t2c_port2", 64'(pa),   64'h2);
        check("t2c_sa2",   64'(sa_a), 64'(sa_of(2, 20)));
        tick();
        check("t2c_port0b", 64'(pa),   64'h0);
        check("t2c_sa0b",   64'(sa_a), 64'(sa_of(0, 21)));

        // ---- Fixed priority: port 0 keeps winning while it re-posts ----
        apply_reset();
        for (int k = 0; k < 4; k++) db[k*48 +: 48] = sa_of(k, 3);
        vb = 4'hF;
        tick();
        for (int c = 0; c < 4; c++) begin
            db[0 +: 48] = sa_of(0, 10 + c);
            vb = 4'b0001;
            tick();
            check($sformatf("t3_port_c%0d", c),  64'(pb),   64'h0);
            check($sformatf("t3_sa_c%0d", c),    64'(sa_b),
                  64'((c == 0) ? sa_of(0, 3) : sa_of(0, 10 + c - 1)));
            check($sformatf("t3_grant_c%0d", c), 64'(gb),   64'h1);
        end
        vb = '0;
        tick();
        check("t3_port0_last", 64'(pb),   64'h0);
        check("t3_sa0_last",   64'(sa_b), 64'(sa_of(0, 13)));
        for (int k = 1; k < 4; k++) begin
            tick();
            check($sformatf("t3_port%0d", k), 64'(pb),   64'(k));
            check($sformatf("t3_sa%0d", k),   64'(sa_b), 64'(sa_of(k, 3)));
        end
        check("t3_drop", 64'(drb), 64'h0);

        // ---- Back-pressure, drops and saturation (2-bit counters) ----
        apply_reset();
        rc = 1'b0;
        dc[1*48 +: 48] = sa_of(1, 4);
        vc = 4'b0010;
        tick();
        vc = '0;
        tick();
        check("t4_load_valid", 64'(ovc),  64'h1);
        check("t4_load_port",  64'(pc),   64'h1);
        check("t4_load_sa",    64'(sa_c), 64'(sa_of(1, 4)));
        check("t4_load_grant", 64'(gc),   64'h2);
        for (int c = 0; c < 5; c++) begin
            if (c == 0) begin
                dc[1*48 +: 48] = sa_of(1, 5);
                vc = 4'b0010;
            end else if (c < 3) begin
                dc[1*48 +: 48] = sa_of(1, 6);
                vc = 4'b0010;
            end else begin
                vc = '0;
            end
            tick();
            check($sformatf("t4_stall_valid%0d", c), 64'(ovc),  64'h1);
            check($sformatf("t4_stall_port%0d", c),  64'(pc),   64'h1);
            check($sformatf("t4_stall_sa%0d", c),    64'(sa_c), 64'(sa_of(1, 4)));
            check($sformatf("t4_stall_grant%0d", c), 64'(gc),   64'h0);
        end
        check("t4_drop_two", 64'(drc[2 +: 2]), 64'h2);
        vc = 4'b0010;
        for (int c = 0; c < 3; c++) tick();
        vc = '0;
        check("t4_drop_sat", 64'(drc), 64'h0C);
        rc = 1'b1;
        tick();
        check("t4_drain_port",  64'(pc),   64'h1);
        check("t4_drain_sa",    64'(sa_c), 64'(sa_of(1, 5)));
        check("t4_drain_grant", 64'(gc),   64'h2);
        tick();
        check("t4_drain_idle", 64'(ovc), 64'h0);

        // ---- Port 3 re-posts on the cycle its slot is granted ----
        apply_reset();
        da[3*48 +: 48] = sa_of(3, 7);
        va = 4'b1000;
        tick();
        da[3*48 +: 48] = sa_of(3, 8);
        tick();
        va = '0;
        check("t5_port_first",  64'(pa),   64'h3);
        check("t5_sa_first",    64'(sa_a), 64'(sa_of(3, 7)));
        check("t5_grant_first", 64'(ga),   64'h8);
        tick();
        check("t5_valid_second", 64'(ova),  64'h1);
        check("t5_sa_second",    64'(sa_a), 64'(sa_of(3, 8)));
        check("t5_grant_second", 64'(ga),   64'h8);
        check("t5_drop",         64'(dra),  64'h0);

        // ---- Reset in the middle of traffic ----
        apply_reset();
        ra = 1'b0;
        for (int k = 0; k < 4; k++) da[k*48 +: 48] = sa_of(k, 9);
        va = 4'hF;
        tick();
        va = 4'b0010;
        tick();
        va = '0;
        check("t6_pre_valid", 64'(ova), 64'h1);
        check("t6_pre_port",  64'(pa),  64'h0);
        check("t6_pre_drop",  64'(dra), 64'h0000_0100);
        rst_n = 1'b0;
        tick();
        check("t6_rst_valid", 64'(ova),  64'h0);
        check("t6_rst_port",  64'(pa),   64'h0);
        check("t6_rst_sa",    64'(sa_a), 64'h0);
        check("t6_rst_grant", 64'(ga),   64'h0);
        check("t6_rst_drop",  64'(dra),  64'h0);
        rst_n = 1'b1;
        ra = 1'b1;
        tick();
        check("t6_post_valid", 64'(ova), 64'h0);
        tick();
        check("t6_post_valid2", 64'(ova), 64'h0);

        // ---- Three ports: pointer wraps from 2 to 0 ----
        apply_reset();
        for (int k = 0; k < 3; k++) dd[k*48 +: 48] = sa_of(k, 11);
        vd = 3'b111;
        tick();
        vd = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("t7_port%0d", k), 64'(pd), 64'(k));
            check($sformatf("t7_grant%0d", k), 64'(gd), 64'(1 << k));
        end
        vd = 3'b011;
        tick();
        vd = '0;
        tick();
        check("t7_wrap_port0", 64'(pd), 64'h0);
        tick();
        check("t7_wrap_port1", 64'(pd), 64'h1);
        vd = 3'b101;
        tick();
        vd = '0;
        tick();
        check("t7_ptr2_port2", 64'(pd), 64'h2);
        tick();
        check("t7_ptr0_port0", 64'(pd),   64'h0);
        check("t7_ptr0_sa0",   64'(sa_d), 64'(sa_of(0, 11)));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_mac_learn_arbiter
